// File: rtl/pixel_sequencer.sv
// pixel_sequencer: frame sequencer for the pixel array.
// Runs erase -> programmable exposure -> ramp-ADC conversion -> N-group readout.
// Supports continuous mode, abort, and a one-cycle frame-done pulse.
// All outputs are registered and decoded from the next state, so each strobe
// lines up exactly with the cycles spent in its state.
module pixel_sequencer #(
  parameter int ADC_BITS     = 8,
  parameter int NUM_GROUPS   = 2,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_CYCLES  = 5,
  parameter int EXP_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  contMode,
  input  logic [EXP_W-1:0]      expTime,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic [NUM_GROUPS-1:0] read,
  output logic                  anaReset,
  output logic                  anaBias1,
  output logic                  anaRamp,
  output logic [ADC_BITS-1:0]   cntData,
  output logic                  busy,
  output logic                  frameDone
);

  // The phase counter must hold the longest phase length minus one.
  localparam int W0 = (ADC_BITS > EXP_W) ? ADC_BITS : EXP_W;
  localparam int W1 = $clog2(ERASE_CYCLES + 1);
  localparam int W2 = $clog2(READ_CYCLES + 1);
  localparam int W3 = (W0 > W1) ? W0 : W1;
  localparam int CW = ((W3 > W2) ? W3 : W2) + 1;
  localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [GW-1:0]           grp_q, grp_d;
  logic [EXP_W-1:0]        exp_q, exp_d;
  logic [ADC_BITS-1:0]     cnt_data_q, cnt_data_d;
  logic                    erase_q, erase_d;
  logic                    expose_q, expose_d;
  logic                    convert_q, convert_d;
  logic [NUM_GROUPS-1:0]   read_q, read_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;

  logic [EXP_W-1:0]        exp_in;
  logic [CW-1:0]           exp_last;

  // A zero exposure request is stretched to one cycle.
  assign exp_in   = (expTime == '0) ? EXP_W'(1) : expTime;
  assign exp_last = CW'(exp_q) - CW'(1);

  // Next-state, phase counters and decoded outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    grp_d        = grp_q;
    exp_d        = exp_q;
    cnt_data_d   = cnt_data_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && !abort) begin
          state_d = S_ERASE;
          exp_d   = exp_in;
        end
      end
      S_ERASE: begin
        if (cnt_q == CW'(ERASE_CYCLES - 1)) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == exp_last) begin
          state_d    = S_CONVERT;
          cnt_d      = '0;
          cnt_data_d = '0;
        end
      end
      S_CONVERT: begin
        // The conversion count itself times the phase; it stops at all-ones
        // and holds there for the column latches.
        if (cnt_data_q == '1) begin
          state_d = S_READ;
          cnt_d   = '0;
          grp_d   = '0;
        end else begin
          cnt_data_d = cnt_data_q + ADC_BITS'(1);
        end
      end
      S_READ: begin
        if (cnt_q == CW'(READ_CYCLES - 1)) begin
          cnt_d = '0;
          if (grp_q == GW'(NUM_GROUPS - 1)) begin
            grp_d        = '0;
            frame_done_d = 1'b1;
            if (contMode) begin
              state_d = S_ERASE;
              exp_d   = exp_in;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            grp_d = grp_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides every transition, including the frame-done one.
    if (abort && state_q != S_IDLE) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      grp_d        = '0;
      cnt_data_d   = '0;
      frame_done_d = 1'b0;
    end
    erase_d   = (state_d == S_ERASE);
    expose_d  = (state_d == S_EXPOSE);
    convert_d = (state_d == S_CONVERT);
    busy_d    = (state_d != S_IDLE);
    read_d    = (state_d == S_READ) ? (NUM_GROUPS'(1) << grp_d) : '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      grp_q        <= '0;
      exp_q        <= '0;
      cnt_data_q   <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grp_q        <= grp_d;
      exp_q        <= exp_d;
      cnt_data_q   <= cnt_data_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      read_q       <= read_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign erase     = erase_q;
  assign anaReset  = erase_q;
  assign expose    = expose_q;
  assign convert   = convert_q;
  assign anaBias1  = convert_q;
  assign anaRamp   = convert_q;
  assign read      = read_q;
  assign cntData   = cnt_data_q;
  assign busy      = busy_q;
  assign frameDone = frame_done_q;

endmodule
